// File: rtl/ysyx_25040105_mc_core_ctrl.sv
// Multi-cycle sequencer for the ysyx_25040105 core: owns pc, the instruction register,
// the fetch and load/store handshakes, write-back, halt and the cycle/instret counters.
module ysyx_25040105_mc_core_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch
  output logic              if_req_valid,
  input  logic              if_req_ready,
  output logic [XLEN-1:0]   if_addr,
  input  logic              if_rsp_valid,
  input  logic [31:0]       if_rsp_data,
  output logic [31:0]       inst,
  output logic [XLEN-1:0]   pc,
  // decode results, meaningful in EXEC only
  input  logic              dec_jump_en,
  input  logic [XLEN-1:0]   dec_jump_addr,
  input  logic              dec_reg_wen,
  input  logic [XLEN-1:0]   dec_alu_result,
  input  logic              dec_mem_ren,
  input  logic              dec_mem_wen,
  input  logic [1:0]        dec_mem_len,
  input  logic              dec_load_signed,
  input  logic [XLEN-1:0]   dec_mem_addr,
  input  logic [XLEN-1:0]   dec_mem_wdata,
  input  logic              dec_is_ebreak,
  input  logic              a0_zero,
  // load/store
  output logic              ls_req_valid,
  input  logic              ls_req_ready,
  output logic              ls_req_wen,
  output logic [XLEN-1:0]   ls_addr,
  output logic [XLEN-1:0]   ls_wdata,
  output logic [XLEN/8-1:0] ls_wmask,
  input  logic              ls_rsp_valid,
  input  logic [XLEN-1:0]   ls_rsp_rdata,
  // write-back and status
  output logic              rf_wen,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              retire,
  output logic              halt,
  output logic [1:0]        halt_code,
  output logic [63:0]       mcycle,
  output logic [63:0]       minstret
);

  localparam int unsigned BW = XLEN / 8;
  localparam int unsigned OW = $clog2(BW);

  localparam logic [2:0] S_RESET      = 3'd0;
  localparam logic [2:0] S_FETCH_REQ  = 3'd1;
  localparam logic [2:0] S_FETCH_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC       = 3'd3;
  localparam logic [2:0] S_MEM_REQ    = 3'd4;
  localparam logic [2:0] S_MEM_WAIT   = 3'd5;
  localparam logic [2:0] S_WB         = 3'd6;
  localparam logic [2:0] S_HALT       = 3'd7;

  localparam logic [1:0] HC_GOOD     = 2'd0;
  localparam logic [1:0] HC_BAD      = 2'd1;
  localparam logic [1:0] HC_TIMEOUT  = 2'd2;
  localparam logic [1:0] HC_MISALIGN = 2'd3;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, npc_q, npc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_wen_q, wb_wen_d;
  logic [XLEN-1:0] maddr_q, maddr_d, mwdata_q, mwdata_d;
  logic [1:0]      mlen_q, mlen_d;
  logic            mwen_q, mwen_d, msigned_q, msigned_d;
  logic [1:0]      halt_code_q, halt_code_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [63:0]     mcycle_q, minstret_q;

  logic            misaligned;
  logic            tmo_expire;
  logic [OW-1:0]   moff;
  logic [BW-1:0]   wmask_base;
  logic [XLEN-1:0] rd_shifted, rd_mask, rd_top, load_data;

  // D accesses have no natural home on a 32-bit datapath, so they trap like a misalignment.
  always_comb begin
    unique case (dec_mem_len)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = dec_mem_addr[0];
      2'd2:    misaligned = |dec_mem_addr[1:0];
      default: misaligned = (XLEN != 64) || (|dec_mem_addr[2:0]);
    endcase
  end

  assign tmo_expire = (TIMEOUT != 0) && (tmo_q == 32'(TIMEOUT - 1));
  assign moff       = maddr_q[OW-1:0];

  always_comb begin
    unique case (mlen_q)
      2'd0:    begin wmask_base = BW'(8'h01); rd_mask = XLEN'(64'hFF);        end
      2'd1:    begin wmask_base = BW'(8'h03); rd_mask = XLEN'(64'hFFFF);      end
      2'd2:    begin wmask_base = BW'(8'h0F); rd_mask = XLEN'(64'hFFFF_FFFF); end
      default: begin wmask_base = BW'(8'hFF); rd_mask = '1;                   end
    endcase
  end

  // The sign bit is the top bit of the truncated field, located by the mask's MSB.
  assign rd_shifted = ls_rsp_rdata >> {moff, 3'b000};
  assign rd_top     = rd_mask & ~(rd_mask >> 1);
  assign load_data  = (rd_shifted & rd_mask)
                    | ((msigned_q && |(rd_shifted & rd_top)) ? ~rd_mask : '0);

  // NOTE: every next-state signal takes its hold value first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    npc_d       = npc_q;
    inst_d      = inst_q;
    wb_data_d   = wb_data_q;
    wb_wen_d    = wb_wen_q;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    mlen_d      = mlen_q;
    mwen_d      = mwen_q;
    msigned_d   = msigned_q;
    halt_code_d = halt_code_q;
    tmo_d       = tmo_q;
    unique case (state_q)
      S_RESET: state_d = S_FETCH_REQ;
      S_FETCH_REQ: begin
        if (if_req_ready) begin
          state_d = S_FETCH_WAIT;
          tmo_d   = '0;
        end
      end
      S_FETCH_WAIT: begin
        if (if_rsp_valid) begin
          inst_d  = if_rsp_data;
          state_d = S_EXEC;
        end else if (tmo_expire) begin
          halt_code_d = HC_TIMEOUT;
          state_d     = S_HALT;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_EXEC: begin
        npc_d     = dec_jump_en ? dec_jump_addr : pc_q + XLEN'(4);
        wb_data_d = dec_alu_result;
        wb_wen_d  = dec_reg_wen;
        if (dec_is_ebreak) begin
          halt_code_d = a0_zero ? HC_GOOD : HC_BAD;
          state_d     = S_HALT;
        end else if (dec_mem_ren || dec_mem_wen) begin
          if (misaligned) begin
            halt_code_d = HC_MISALIGN;
            state_d     = S_HALT;
          end else begin
            maddr_d   = dec_mem_addr;
            mwdata_d  = dec_mem_wdata;
            mlen_d    = dec_mem_len;
            mwen_d    = dec_mem_wen;
            msigned_d = dec_load_signed;
            state_d   = S_MEM_REQ;
          end
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_REQ: begin
        if (ls_req_ready) begin
          state_d = S_MEM_WAIT;
          tmo_d   = '0;
        end
      end
      S_MEM_WAIT: begin
        if (ls_rsp_valid) begin
          if (!mwen_q) begin
            wb_data_d = load_data;
            wb_wen_d  = 1'b1;
          end
          state_d = S_WB;
        end else if (tmo_expire) begin
          halt_code_d = HC_TIMEOUT;
          state_d     = S_HALT;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_WB: begin
        pc_d    = npc_q;
        state_d = S_FETCH_REQ;
      end
      default: ;  // S_HALT is sticky until reset
    endcase
  end

  // NOTE: state updates use non-blocking assignments and reset asynchronously on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RESET;
      pc_q        <= RESET_PC;
      npc_q       <= '0;
      inst_q      <= '0;
      wb_data_q   <= '0;
      wb_wen_q    <= 1'b0;
      maddr_q     <= '0;
      mwdata_q    <= '0;
      mlen_q      <= '0;
      mwen_q      <= 1'b0;
      msigned_q   <= 1'b0;
      halt_code_q <= '0;
      tmo_q       <= '0;
      mcycle_q    <= '0;
      minstret_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      inst_q      <= inst_d;
      wb_data_q   <= wb_data_d;
      wb_wen_q    <= wb_wen_d;
      maddr_q     <= maddr_d;
      mwdata_q    <= mwdata_d;
      mlen_q      <= mlen_d;
      mwen_q      <= mwen_d;
      msigned_q   <= msigned_d;
      halt_code_q <= halt_code_d;
      tmo_q       <= tmo_d;
      if (state_q != S_RESET && state_q != S_HALT) mcycle_q <= mcycle_q + 64'd1;
      if (state_q == S_WB) minstret_q <= minstret_q + 64'd1;
    end
  end

  // Request payloads come straight from registers, so they stay stable while valid waits.
  assign if_req_valid = (state_q == S_FETCH_REQ);
  assign if_addr      = pc_q;
  assign inst         = inst_q;
  assign pc           = pc_q;

  assign ls_req_valid = (state_q == S_MEM_REQ);
  assign ls_req_wen   = mwen_q;
  assign ls_addr      = maddr_q & ~XLEN'(BW - 1);
  assign ls_wdata     = mwdata_q << {moff, 3'b000};
  assign ls_wmask     = wmask_base << moff;

  assign retire       = (state_q == S_WB);
  assign rf_wen       = (state_q == S_WB) && wb_wen_q;
  assign rf_wdata     = wb_data_q;
  assign halt         = (state_q == S_HALT);
  assign halt_code    = halt_code_q;
  assign mcycle       = mcycle_q;
  assign minstret     = minstret_q;

endmodule

// File: tb/tb_ysyx_25040105_mc_core_ctrl.sv
// Directed bench for the multi-cycle sequencer: ALU/jump retire, stalls, loads, stores,
// traps, bus timeout and asynchronous reset, with hand-computed expected values.
module tb_ysyx_25040105_mc_core_ctrl;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rsp_data, inst, pc;
  logic        dec_jump_en, dec_reg_wen, dec_mem_ren, dec_mem_wen, dec_load_signed;
  logic        dec_is_ebreak, a0_zero;
  logic [1:0]  dec_mem_len;
  logic [31:0] dec_jump_addr, dec_alu_result, dec_mem_addr, dec_mem_wdata;
  logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_rsp_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rsp_rdata;
  logic [3:0]  ls_wmask;
  logic        rf_wen, retire, halt;
  logic [31:0] rf_wdata;
  logic [1:0]  halt_code;
  logic [63:0] mcycle, minstret;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [63:0] m0;

  ysyx_25040105_mc_core_ctrl #(.XLEN(XLEN), .RESET_PC(RESET_PC), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .inst(inst), .pc(pc),
    .dec_jump_en(dec_jump_en), .dec_jump_addr(dec_jump_addr),
    .dec_reg_wen(dec_reg_wen), .dec_alu_result(dec_alu_result),
    .dec_mem_ren(dec_mem_ren), .dec_mem_wen(dec_mem_wen), .dec_mem_len(dec_mem_len),
    .dec_load_signed(dec_load_signed), .dec_mem_addr(dec_mem_addr),
    .dec_mem_wdata(dec_mem_wdata), .dec_is_ebreak(dec_is_ebreak), .a0_zero(a0_zero),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wen(ls_req_wen),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
    .rf_wen(rf_wen), .rf_wdata(rf_wdata), .retire(retire),
    .halt(halt), .halt_code(halt_code), .mcycle(mcycle), .minstret(minstret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    dec_jump_en = 0; dec_jump_addr = '0; dec_reg_wen = 0; dec_alu_result = '0;
    dec_mem_ren = 0; dec_mem_wen = 0; dec_mem_len = '0; dec_load_signed = 0;
    dec_mem_addr = '0; dec_mem_wdata = '0; dec_is_ebreak = 0; a0_zero = 0;
  endtask

  task automatic clear_bus();
    if_req_ready = 0; if_rsp_valid = 0; if_rsp_data = '0;
    ls_req_ready = 0; ls_rsp_valid = 0; ls_rsp_rdata = '0;
  endtask

  // Assert reset between edges, check reset values, release, land in FETCH_REQ.
  task automatic do_reset();
    rst = 0;
    #1;
    clear_dec();
    clear_bus();
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, 0);
    check("rst_if_valid", if_req_valid, 0);
    check("rst_ls_valid", ls_req_valid, 0);
    check("rst_halt", halt, 0);
    check("rst_halt_code", halt_code, 0);
    check("rst_retire", retire, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_mcycle", mcycle, 0);
    check("rst_minstret", minstret, 0);
    step();
    rst = 1;
    step();
    check("post_rst_if_valid", if_req_valid, 1);
    check("post_rst_if_addr", if_addr, RESET_PC);
    exp_pc = RESET_PC;
  endtask

  // From FETCH_REQ: accept, respond next cycle, end in EXEC.
  task automatic fetch(input logic [31:0] word);
    check("fetch_valid", if_req_valid, 1);
    check("fetch_addr", if_addr, exp_pc);
    if_req_ready = 1;
    step();
    if_req_ready = 0;
    if_rsp_valid = 1;
    if_rsp_data  = word;
    step();
    if_rsp_valid = 0;
    check("fetch_inst", inst, word);
  endtask

  // From EXEC: ALU or jump instruction through WB back to FETCH_REQ.
  task automatic alu_op(input logic [31:0] res, input logic jmp, input logic [31:0] tgt);
    dec_reg_wen = 1; dec_alu_result = res; dec_jump_en = jmp; dec_jump_addr = tgt;
    step();
    clear_dec();
    check("wb_retire", retire, 1);
    check("wb_rf_wen", rf_wen, 1);
    check("wb_rf_wdata", rf_wdata, res);
    check("wb_pc_old", pc, exp_pc);
    step();
    exp_pc = jmp ? tgt : exp_pc + 32'd4;
    check("next_pc", pc, exp_pc);
    check("retire_drop", retire, 0);
  endtask

  task automatic load_op(input logic [31:0] addr, input logic [1:0] len, input logic sgn,
                         input logic [31:0] rdata, input logic [31:0] exp);
    logic [63:0] c0;
    c0 = mcycle;
    fetch(32'h0000_0003);
    dec_mem_ren = 1; dec_mem_len = len; dec_load_signed = sgn;
    dec_mem_addr = addr; dec_reg_wen = 1; dec_alu_result = addr;
    step();
    clear_dec();
    check("ld_req_valid", ls_req_valid, 1);
    check("ld_req_wen", ls_req_wen, 0);
    check("ld_addr", ls_addr, addr & 32'hFFFF_FFFC);
    ls_req_ready = 1;
    step();
    ls_req_ready = 0;
    check("ld_req_drop", ls_req_valid, 0);
    ls_rsp_valid = 1; ls_rsp_rdata = rdata;
    step();
    ls_rsp_valid = 0;
    check("ld_retire", retire, 1);
    check("ld_rf_wen", rf_wen, 1);
    check("ld_rf_wdata", rf_wdata, exp);
    step();
    exp_pc = exp_pc + 32'd4;
    check("ld_next_pc", pc, exp_pc);
    check("ld_latency", mcycle, c0 + 64'd6);
  endtask

  initial begin
    rst = 1;
    clear_dec();
    clear_bus();
    #1;
    do_reset();

    // addi: best-case 4-cycle ALU instruction
    check("mcycle_start", mcycle, 0);
    fetch(32'h0050_0093);
    check("mcycle_exec", mcycle, 2);
    alu_op(32'd5, 0, '0);
    check("minstret_1", minstret, 1);
    check("mcycle_4", mcycle, 4);

    // fetch stall: valid and address held, cycles still counted
    m0 = mcycle;
    for (int i = 0; i < 7; i++) begin
      step();
      check("stall_valid", if_req_valid, 1);
      check("stall_addr", if_addr, exp_pc);
    end
    check("stall_mcycle", mcycle, m0 + 64'd7);
    fetch(32'h0fc0_00ef);
    alu_op(32'h8000_0008, 1, 32'h8000_0100);
    check("minstret_2", minstret, 2);

    // response in the last permitted waiting cycle is accepted
    if_req_ready = 1;
    step();
    if_req_ready = 0;
    for (int i = 0; i < 3; i++) step();
    check("tmo_edge_halt", halt, 0);
    check("tmo_edge_inst_hold", inst, 32'h0fc0_00ef);
    if_rsp_valid = 1; if_rsp_data = 32'h0010_0513;
    step();
    if_rsp_valid = 0;
    check("tmo_edge_no_halt", halt, 0);
    check("tmo_edge_inst", inst, 32'h0010_0513);
    alu_op(32'd1, 0, '0);

    // loads: signed/unsigned byte at offset 3, signed half at offset 2
    load_op(32'h8000_0103, 2'd0, 1, 32'h8012_3456, 32'hFFFF_FF80);
    load_op(32'h8000_0103, 2'd0, 0, 32'h8012_3456, 32'h0000_0080);
    load_op(32'h8000_0106, 2'd1, 1, 32'h8765_4321, 32'hFFFF_8765);
    load_op(32'h8000_0108, 2'd2, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // store half at offset 2, back-pressured, with a stray response while waiting for ready
    fetch(32'h00a1_1123);
    dec_mem_wen = 1; dec_mem_len = 2'd1; dec_mem_addr = 32'h8000_0202;
    dec_mem_wdata = 32'h0000_1234;
    step();
    clear_dec();
    check("st_valid", ls_req_valid, 1);
    check("st_wen", ls_req_wen, 1);
    check("st_addr", ls_addr, 32'h8000_0200);
    check("st_wmask", ls_wmask, 4'b1100);
    check("st_wdata", ls_wdata, 32'h1234_0000);
    ls_rsp_valid = 1;
    step();
    step();
    ls_rsp_valid = 0;
    check("st_hold_valid", ls_req_valid, 1);
    check("st_hold_wmask", ls_wmask, 4'b1100);
    check("st_hold_wdata", ls_wdata, 32'h1234_0000);
    ls_req_ready = 1;
    step();
    ls_req_ready = 0;
    ls_rsp_valid = 1; ls_rsp_rdata = 32'hDEAD_BEEF;
    step();
    ls_rsp_valid = 0;
    check("st_retire", retire, 1);
    check("st_rf_wen", rf_wen, 0);
    step();
    exp_pc = exp_pc + 32'd4;
    check("st_next_pc", pc, exp_pc);

    // misaligned word load traps without touching the bus; HALT freezes mcycle
    fetch(32'h0000_2003);
    dec_mem_ren = 1; dec_mem_len = 2'd2; dec_mem_addr = 32'h8000_0002; dec_reg_wen = 1;
    step();
    clear_dec();
    check("mis_halt", halt, 1);
    check("mis_code", halt_code, 3);
    check("mis_ls_valid", ls_req_valid, 0);
    check("mis_pc_hold", pc, exp_pc);
    m0 = mcycle;
    for (int i = 0; i < 3; i++) step();
    check("halt_mcycle_frozen", mcycle, m0);
    check("halt_sticky", halt, 1);
    check("halt_if_valid", if_req_valid, 0);
    check("halt_retire", retire, 0);
    do_reset();

    // ebreak with a0 != 0 -> bad trap; with a0 == 0 -> good trap
    fetch(32'h0010_0073);
    dec_is_ebreak = 1; a0_zero = 0; dec_reg_wen = 1;
    step();
    clear_dec();
    check("ebreak_bad_halt", halt, 1);
    check("ebreak_bad_code", halt_code, 1);
    check("ebreak_bad_rf_wen", rf_wen, 0);
    check("ebreak_bad_minstret", minstret, 0);
    do_reset();
    fetch(32'h0010_0073);
    dec_is_ebreak = 1; a0_zero = 1;
    step();
    clear_dec();
    check("ebreak_good_halt", halt, 1);
    check("ebreak_good_code", halt_code, 0);
    check("ebreak_good_inst", inst, 32'h0010_0073);
    do_reset();

    // fetch timeout after 4 silent waiting cycles
    if_req_ready = 1;
    step();
    if_req_ready = 0;
    for (int i = 0; i < 3; i++) step();
    check("tmo_not_yet", halt, 0);
    step();
    check("tmo_halt", halt, 1);
    check("tmo_code", halt_code, 2);
    check("tmo_pc", pc, RESET_PC);
    do_reset();

    // reset asserted mid-MEM_WAIT; the late response must be ignored
    fetch(32'h0000_2003);
    dec_mem_ren = 1; dec_mem_len = 2'd2; dec_mem_addr = 32'h8000_0010; dec_reg_wen = 1;
    step();
    clear_dec();
    ls_req_ready = 1;
    step();
    ls_req_ready = 0;
    check("mw_ls_valid", ls_req_valid, 0);
    check("mw_halt", halt, 0);
    rst = 0;
    #1;
    check("arst_pc", pc, RESET_PC);
    check("arst_inst", inst, 0);
    check("arst_mcycle", mcycle, 0);
    check("arst_if_valid", if_req_valid, 0);
    check("arst_ls_valid", ls_req_valid, 0);
    ls_rsp_valid = 1; ls_rsp_rdata = 32'h1111_2222;
    step();
    rst = 1;
    step();
    check("restart_if_valid", if_req_valid, 1);
    check("restart_if_addr", if_addr, RESET_PC);
    step();
    ls_rsp_valid = 0;
    check("late_rsp_rf_wen", rf_wen, 0);
    check("late_rsp_retire", retire, 0);
    check("late_rsp_minstret", minstret, 0);
    check("late_rsp_still_fetch", if_req_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
